mcp3008_sampler: RTL and testbench

//   Periodic multi-channel sequencer for an MCP3008 8-ch 10-bit SPI ADC.

---
 rtl/mcp3008_sampler_if.sv | 24 ++
 rtl/mcp3008_sampler.sv | 147 ++++++++++++++
 tb/tb_mcp3008_sampler.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp3008_sampler_if.sv
// Bus between the MCP3008 sampler, the SPI controller and the sample consumer.
// Handshakes: spi_axiiv is a single-cycle request that only rises while spi_axiready is
// high; sample_valid holds with stable data/channel until a cycle where sample_ready is high.
interface mcp3008_sampler_if;
    logic        spi_axiiv;
    logic [23:0] spi_axiid;
    logic        spi_axiready;
    logic        spi_axiov;
    logic [23:0] spi_axiod;
    logic        sample_valid;
    logic        sample_ready;
    logic [9:0]  sample_data;
    logic [2:0]  sample_channel;

    modport master (
        output spi_axiiv, spi_axiid, sample_valid, sample_data, sample_channel,
        input  spi_axiready, spi_axiov, spi_axiod, sample_ready
    );

    modport slave (
        input  spi_axiiv, spi_axiid, sample_valid, sample_data, sample_channel,
        output spi_axiready, spi_axiov, spi_axiod, sample_ready
    );
endinterface

// File: rtl/mcp3008_sampler.sv
// Periodic sweep sequencer for an MCP3008: one 24-bit SPI transaction per enabled channel,
// 10-bit result forwarded downstream as {channel, sample} on valid/ready.
module mcp3008_sampler #(
    parameter logic [7:0]  CHANNEL_MASK   = 8'hFF,
    parameter int unsigned SAMPLE_PERIOD  = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    mcp3008_sampler_if.master        bus,
    input  logic                     clear_errors,
    output logic                     overrun,
    output logic                     timeout_err,
    output logic [1:0]               fsm_state
);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [WW-1:0] WDOG_LAST   = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, AWAIT, PUSH} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] period_cnt;
    logic [WW-1:0] wdog;
    logic [2:0]    ch_q, ch_d;
    logic [23:0]   cmd_q;
    logic [9:0]    adc_q;
    logic          valid_q;
    logic [9:0]    data_q;
    logic [2:0]    chan_q;
    logic          tick;
    logic          load_cmd, issue, capture, push_load, push_drop, wdog_expire;
    logic [3:0]    first_hit, next_hit;
    logic          unused_upper;

    // {found, channel} of the lowest mask bit at or above 'from'; never wraps past 7.
    function automatic logic [3:0] find_ch(input logic [3:0] from);
        logic [3:0] hit;
        hit = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (CHANNEL_MASK[i] && (4'(i) >= from)) hit = {1'b1, 3'(i)};
        end
        return hit;
    endfunction

    function automatic logic [23:0] cmd_word(input logic [2:0] ch);
        return {8'h01, 1'b1, ch, 4'h0, 8'h00};
    endfunction

    assign tick         = (period_cnt == PERIOD_LAST);
    assign first_hit    = find_ch(4'd0);
    assign next_hit     = find_ch({1'b0, ch_q} + 4'd1);
    assign unused_upper = ^bus.spi_axiod[23:10];

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        load_cmd    = 1'b0;
        issue       = 1'b0;
        capture     = 1'b0;
        push_load   = 1'b0;
        push_drop   = 1'b0;
        wdog_expire = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && enable && first_hit[3]) begin
                    ch_d     = first_hit[2:0];
                    load_cmd = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.spi_axiready) begin
                    issue   = 1'b1;
                    state_d = AWAIT;
                end
            end
            AWAIT: begin
                if (bus.spi_axiov) begin
                    capture = 1'b1;
                    state_d = PUSH;
                end else if (wdog == WDOG_LAST) begin
                    wdog_expire = 1'b1;
                    state_d     = IDLE;
                end
            end
            PUSH: begin
                if (!valid_q || bus.sample_ready) push_load = 1'b1;
                else                              push_drop = 1'b1;
                // A disable only takes effect here, so an in-flight conversion is always delivered.
                if (!enable || !next_hit[3]) begin
                    state_d = IDLE;
                end else begin
                    ch_d     = next_hit[2:0];
                    load_cmd = 1'b1;
                    state_d  = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            period_cnt  <= '0;
            wdog        <= '0;
            ch_q        <= 3'd0;
            cmd_q       <= 24'h0;
            adc_q       <= 10'h0;
            valid_q     <= 1'b0;
            data_q      <= 10'h0;
            chan_q      <= 3'd0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (tick) period_cnt <= '0;
            else      period_cnt <= period_cnt + 1'b1;
            if (issue)                wdog <= '0;
            else if (state_q == AWAIT) wdog <= wdog + 1'b1;
            if (load_cmd) cmd_q <= cmd_word(ch_d);
            if (capture)  adc_q <= bus.spi_axiod[9:0];
            if (push_load) begin
                valid_q <= 1'b1;
                data_q  <= adc_q;
                chan_q  <= ch_q;
            end else if (valid_q && bus.sample_ready) begin
                valid_q <= 1'b0;
            end
            if (push_drop)         overrun <= 1'b1;
            else if (clear_errors) overrun <= 1'b0;
            if (wdog_expire)       timeout_err <= 1'b1;
            else if (clear_errors) timeout_err <= 1'b0;
        end
    end

    assign bus.spi_axiiv      = issue;
    assign bus.spi_axiid      = cmd_q;
    assign bus.sample_valid   = valid_q;
    assign bus.sample_data    = data_q;
    assign bus.sample_channel = chan_q;
    assign fsm_state          = state_q;
endmodule

// File: tb/tb_mcp3008_sampler.sv
// Directed bench for mcp3008_sampler: full-mask, sparse-mask and empty-mask instances
// driven against a small MCP3008/SPI response model.
module tb_mcp3008_sampler;
    localparam int PERIOD = 300;
    localparam int TMO    = 50;

    typedef struct {
        logic [2:0]  ch;
        logic [23:0] id;
        logic [9:0]  data;
    } vec_t;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic en_a, en_b, en_c, clr_a, clr_b, clr_c, mute_a, mute_b;
    logic ovr_a, ovr_b, ovr_c, tmo_a, tmo_b, tmo_c;
    logic [1:0] st_a, st_b, st_c;

    mcp3008_sampler_if bus_a();
    mcp3008_sampler_if bus_b();
    mcp3008_sampler_if bus_c();

    mcp3008_sampler #(.CHANNEL_MASK(8'hFF), .SAMPLE_PERIOD(PERIOD), .TIMEOUT_CYCLES(TMO)) u_full (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .bus(bus_a), .clear_errors(clr_a),
        .overrun(ovr_a), .timeout_err(tmo_a), .fsm_state(st_a)
    );
    mcp3008_sampler #(.CHANNEL_MASK(8'b1010_0100), .SAMPLE_PERIOD(PERIOD), .TIMEOUT_CYCLES(TMO)) u_sparse (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .bus(bus_b), .clear_errors(clr_b),
        .overrun(ovr_b), .timeout_err(tmo_b), .fsm_state(st_b)
    );
    mcp3008_sampler #(.CHANNEL_MASK(8'h00), .SAMPLE_PERIOD(PERIOD), .TIMEOUT_CYCLES(TMO)) u_none (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .bus(bus_c), .clear_errors(clr_c),
        .overrun(ovr_c), .timeout_err(tmo_c), .fsm_state(st_c)
    );

    // ADC/SPI response model: busy for 4 cycles after a request, then returns 10'h100+ch
    logic       busy_a, busy_b;
    logic [2:0] dly_a, dly_b, mch_a, mch_b;
    assign bus_a.spi_axiready = ~busy_a;
    assign bus_b.spi_axiready = ~busy_b;
    assign bus_c.spi_axiready = 1'b1;
    assign bus_c.spi_axiov    = 1'b0;
    assign bus_c.spi_axiod    = 24'h0;
    assign bus_c.sample_ready = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_a <= 1'b0; dly_a <= 3'd0; mch_a <= 3'd0;
            bus_a.spi_axiov <= 1'b0; bus_a.spi_axiod <= 24'h0;
        end else begin
            bus_a.spi_axiov <= 1'b0;
            if (bus_a.spi_axiiv) begin
                busy_a <= 1'b1; dly_a <= 3'd3; mch_a <= bus_a.spi_axiid[14:12];
            end else if (busy_a) begin
                if (dly_a != 3'd0) dly_a <= dly_a - 3'd1;
                else begin
                    busy_a <= 1'b0;
                    if (!mute_a) begin
                        bus_a.spi_axiov <= 1'b1;
                        bus_a.spi_axiod <= {14'h2AB, 10'h100 + {7'd0, mch_a}};
                    end
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_b <= 1'b0; dly_b <= 3'd0; mch_b <= 3'd0;
            bus_b.spi_axiov <= 1'b0; bus_b.spi_axiod <= 24'h0;
        end else begin
            bus_b.spi_axiov <= 1'b0;
            if (bus_b.spi_axiiv) begin
                busy_b <= 1'b1; dly_b <= 3'd3; mch_b <= bus_b.spi_axiid[14:12];
            end else if (busy_b) begin
                if (dly_b != 3'd0) dly_b <= dly_b - 3'd1;
                else begin
                    busy_b <= 1'b0;
                    if (!mute_b) begin
                        bus_b.spi_axiov <= 1'b1;
                        bus_b.spi_axiod <= {14'h155, 10'h100 + {7'd0, mch_b}};
                    end
                end
            end
        end
    end

    // observed requests and accepted samples
    logic [23:0] req_q_a[$], req_q_b[$], req_q_c[$];
    logic [12:0] got_q_a[$], got_q_b[$];
    logic [12:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_a.spi_axiiv) req_q_a.push_back(bus_a.spi_axiid);
            if (bus_b.spi_axiiv) req_q_b.push_back(bus_b.spi_axiid);
            if (bus_c.spi_axiiv) req_q_c.push_back(bus_c.spi_axiid);
            if (bus_a.sample_valid && bus_a.sample_ready)
                got_q_a.push_back({bus_a.sample_channel, bus_a.sample_data});
            if (bus_b.sample_valid && bus_b.sample_ready)
                got_q_b.push_back({bus_b.sample_channel, bus_b.sample_data});
        end
    end

    // scoreboard bookkeeping
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic at_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < PERIOD + 2; i++) begin
            @(negedge clk);
            if (cyc % PERIOD == p) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_phase_%0d: got timeout expected phase", p);
    endtask

    task automatic wait_req_a(input logic [23:0] id);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if (bus_a.spi_axiiv && bus_a.spi_axiid == id) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_req_%0h: got timeout expected request", id);
    endtask

    task automatic clear_logs();
        req_q_a.delete(); got_q_a.delete(); req_q_b.delete(); got_q_b.delete(); exp_q.delete();
    endtask

    vec_t full_tbl[8];
    vec_t sparse_tbl[3];

    initial begin
        int early;
        logic [12:0] e;

        full_tbl[0] = '{3'd0, 24'h018000, 10'h100};
        full_tbl[1] = '{3'd1, 24'h019000, 10'h101};
        full_tbl[2] = '{3'd2, 24'h01A000, 10'h102};
        full_tbl[3] = '{3'd3, 24'h01B000, 10'h103};
        full_tbl[4] = '{3'd4, 24'h01C000, 10'h104};
        full_tbl[5] = '{3'd5, 24'h01D000, 10'h105};
        full_tbl[6] = '{3'd6, 24'h01E000, 10'h106};
        full_tbl[7] = '{3'd7, 24'h01F000, 10'h107};
        sparse_tbl[0] = '{3'd2, 24'h01A000, 10'h102};
        sparse_tbl[1] = '{3'd5, 24'h01D000, 10'h105};
        sparse_tbl[2] = '{3'd7, 24'h01F000, 10'h107};

        en_a = 0; en_b = 0; en_c = 0; clr_a = 0; clr_b = 0; clr_c = 0;
        mute_a = 0; mute_b = 0;
        bus_a.sample_ready = 1'b1;
        bus_b.sample_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_axiiv", bus_a.spi_axiiv, 0);
        check("rst_axiid", bus_a.spi_axiid, 24'h0);
        check("rst_valid", bus_a.sample_valid, 0);
        check("rst_data", bus_a.sample_data, 0);
        check("rst_channel", bus_a.sample_channel, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_timeout", tmo_a, 0);
        check("rst_state", st_a, 0);
        rst_n = 1'b1;

        // full and sparse sweeps, empty mask never requests
        at_drive();
        en_a = 1; en_b = 1; en_c = 1;
        wait_phase(290);
        wait_phase(150);
        at_drive();
        en_a = 0; en_b = 0;
        check("full_req_count", req_q_a.size(), 8);
        check("full_sample_count", got_q_a.size(), 8);
        for (int i = 0; i < 8; i++) exp_q.push_back({full_tbl[i].ch, full_tbl[i].data});
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full_req_id_ch%0d", full_tbl[i].ch),
                  (i < req_q_a.size()) ? req_q_a[i] : 24'hx, full_tbl[i].id);
            e = exp_q.pop_front();
            check($sformatf("full_sample_ch%0d", full_tbl[i].ch),
                  (i < got_q_a.size()) ? got_q_a[i] : 13'hx, e);
        end
        check("sparse_req_count", req_q_b.size(), 3);
        check("sparse_sample_count", got_q_b.size(), 3);
        for (int i = 0; i < 3; i++) exp_q.push_back({sparse_tbl[i].ch, sparse_tbl[i].data});
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sparse_req_id_ch%0d", sparse_tbl[i].ch),
                  (i < req_q_b.size()) ? req_q_b[i] : 24'hx, sparse_tbl[i].id);
            e = exp_q.pop_front();
            check($sformatf("sparse_sample_ch%0d", sparse_tbl[i].ch),
                  (i < got_q_b.size()) ? got_q_b[i] : 13'hx, e);
        end
        check("none_req_count", req_q_c.size(), 0);
        check("full_overrun_clean", ovr_a, 0);

        // stalled consumer: first sample held, rest dropped
        at_drive();
        clear_logs();
        bus_a.sample_ready = 1'b0;
        en_a = 1;
        wait_phase(290);
        wait_phase(150);
        at_drive();
        en_a = 0;
        @(negedge clk);
        check("stall_valid", bus_a.sample_valid, 1);
        check("stall_channel", bus_a.sample_channel, 0);
        check("stall_data", bus_a.sample_data, 10'h100);
        check("stall_overrun", ovr_a, 1);
        check("stall_req_count", req_q_a.size(), 8);
        at_drive();
        bus_a.sample_ready = 1'b1;
        at_drive();
        @(negedge clk);
        check("stall_drained", bus_a.sample_valid, 0);
        check("stall_got_count", got_q_a.size(), 1);
        check("stall_overrun_sticky", ovr_a, 1);
        check("stall_no_timeout", tmo_a, 0);
        at_drive();
        clr_a = 1;
        at_drive();
        clr_a = 0;
        @(negedge clk);
        check("overrun_cleared", ovr_a, 0);

        // silent ADC: watchdog fires after TMO await cycles, next tick restarts at ch0
        at_drive();
        clear_logs();
        mute_a = 1;
        en_a = 1;
        wait_phase(0);
        check("to_first_req", bus_a.spi_axiiv, 1);
        check("to_first_id", bus_a.spi_axiid, 24'h018000);
        wait_phase(TMO);
        check("to_await_last", st_a, 2);
        check("to_not_yet", tmo_a, 0);
        @(negedge clk);
        check("to_flag", tmo_a, 1);
        check("to_idle", st_a, 0);
        at_drive();
        mute_a = 0;
        wait_phase(0);
        check("to_restart_req", bus_a.spi_axiiv, 1);
        check("to_restart_id", bus_a.spi_axiid, 24'h018000);
        wait_phase(150);
        at_drive();
        en_a = 0;
        check("to_restart_samples", got_q_a.size(), 8);
        check("to_req_count", req_q_a.size(), 9);
        at_drive();
        clr_a = 1;
        at_drive();
        clr_a = 0;
        @(negedge clk);
        check("timeout_cleared", tmo_a, 0);

        // enable drops while channel 3 is in flight
        at_drive();
        clear_logs();
        en_a = 1;
        wait_req_a(24'h01B000);
        @(negedge clk);
        check("dis_in_await", st_a, 2);
        at_drive();
        en_a = 0;
        repeat (40) @(negedge clk);
        check("dis_req_count", req_q_a.size(), 4);
        check("dis_last_id", (req_q_a.size() == 4) ? req_q_a[3] : 24'hx, 24'h01B000);
        check("dis_sample_count", got_q_a.size(), 4);
        check("dis_last_sample", (got_q_a.size() == 4) ? got_q_a[3] : 13'hx, {3'd3, 10'h103});
        check("dis_idle", st_a, 0);

        // asynchronous reset mid-await
        at_drive();
        clear_logs();
        en_a = 1;
        wait_req_a(24'h018000);
        repeat (2) @(negedge clk);
        check("pre_rst_await", st_a, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_axiiv", bus_a.spi_axiiv, 0);
        check("arst_axiid", bus_a.spi_axiid, 24'h0);
        check("arst_valid", bus_a.sample_valid, 0);
        check("arst_state", st_a, 0);
        check("arst_overrun", ovr_a, 0);
        check("arst_timeout", tmo_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        early = 0;
        for (int i = 0; i < PERIOD + 50; i++) begin
            @(negedge clk);
            if (cyc == PERIOD) break;
            if (bus_a.spi_axiiv) early++;
        end
        check("arst_no_early_req", early, 0);
        check("arst_req_after_tick", bus_a.spi_axiiv, 1);
        check("arst_req_id", bus_a.spi_axiid, 24'h018000);
        at_drive();
        en_a = 0;
        repeat (80) @(negedge clk);
        check("none_never_requests", req_q_c.size(), 0);
        check("none_idle", st_c, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
